cheri_tsmap_painter: RTL and testbench
======================================

CHERI_TSMAP_PAINTER -- requirements
Module: cheri_tsmap_painter

Interface
REQ-001 SHALL have parameter HeapBase, 32'h2001_0000, byte address of heap granule 0.
REQ-002 SHALL have parameter TSMapSize, 1024, number of 32-bit TSMAP words.
REQ-003 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1  paint request valid.
REQ-006 SHALL have port req_ready_o  output  1  request accepted when valid and ready are both high.
REQ-007 SHALL have port req_base_i  input  32  byte start address of the region.
REQ-008 SHALL have port req_len_i  input  32  region length in bytes.
REQ-009 SHALL have port req_set_i  input  1  1 = set bits (revoke), 0 = clear bits.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse when the request completes.
REQ-011 SHALL have port err_o  output  1  valid with done_o; high means the request was rejected.
REQ-012 SHALL have port busy_o  output  1  high from acceptance until the done_o cycle inclusive.
REQ-013 SHALL have port tsmap_cs_o  output  1  TSMAP access request.
REQ-014 SHALL have port tsmap_we_o  output  1  1 = write, 0 = read.
REQ-015 SHALL have port tsmap_addr_o  output  16  TSMAP word index.
REQ-016 SHALL have port tsmap_wdata_o  output  32  write data.
REQ-017 SHALL have port tsmap_gnt_i  input  1  access taken this cycle when cs and gnt are both high.
REQ-018 SHALL have port tsmap_rdata_i  input  32  read data, valid in the cycle after a granted read.

Function
REQ-019 Granule mapping SHALL be g = (addr - HeapBase) >> 3, with word = g[31:5] and bit = g[4:0].
REQ-020 At acceptance the block SHALL register g0 = granule(base) and g1 = granule(base + len - 1), computing in 33 bits.
REQ-021 Error conditions SHALL be: base < HeapBase; base + len - 1 overflows 32 bits; or g1[31:5] >= TSMapSize. On error, no TSMAP access occurs.
REQ-022 len == 0 SHALL complete with err_o = 0 and no TSMAP access.
REQ-023 The FSM SHALL have states IDLE, READ, LATCH, WRITE, DONE. req_ready_o SHALL be high only in IDLE.
REQ-024 Acceptance in IDLE SHALL go to DONE if the request is an error or zero-length; otherwise to READ with word = g0[31:5].
REQ-025 READ SHALL drive cs = 1, we = 0, addr = word, and hold until gnt; on gnt it SHALL go to LATCH.
REQ-026 LATCH SHALL capture tsmap_rdata_i into data_q with cs = 0, then go to WRITE.
REQ-027 WRITE SHALL drive cs = 1, we = 1, and wdata = set ? (data_q | mask) : (data_q & ~mask), holding until gnt.
REQ-028 On gnt in WRITE, the FSM SHALL go to DONE if word == g1[31:5]; otherwise it SHALL increment word and go to READ.
REQ-029 mask SHALL be all-ones, with bits below g0[4:0] cleared when word == g0 word, and bits above g1[4:0] cleared when word == g1 word.
REQ-030 DONE SHALL assert done_o for one cycle, with err_o as registered, and return to IDLE.
REQ-031 Outputs SHALL be driven directly from registered state.
REQ-032 Latency with gnt tied high SHALL be: accept at T, done_o at T + 1 + 3*N for N words; error or zero-length gives done_o at T + 1.
REQ-033 tsmap_addr_o and tsmap_wdata_o SHALL stay stable while cs is high and gnt is low.

Reset
REQ-034 On reset, all outputs SHALL be 0 except req_ready_o = 1, and the FSM SHALL be in IDLE.
REQ-035 Reset mid-operation SHALL abandon the request: no further access and no done_o. Words already written stay written.

Structure
REQ-036 TSMAP_GRAN_SHIFT = 3, TSMAP_WORD_BITS = 5, and the painter state enum SHALL live in cheri_pkg.
REQ-037 Mask generation SHALL be a combinational sub-module, cheri_tsmap_mask_gen (inputs lo, hi, first, last; output mask).

Verification
REQ-038 Single-word set: base = HeapBase + 0x10, len = 0x18, set, rdata = 0x0000_0001, gnt = 1 -> write addr 0, data 0x0000_001D; done_o at T + 4, err_o = 0.
REQ-039 Word crossing: base = HeapBase + 0xF8, len = 0x10, set, rdata = 0 -> addr 0 written 0x8000_0000, then addr 1 written 0x0000_0001; done_o at T + 7.
REQ-040 Clear: base = HeapBase, len = 0x100, clear, rdata = 0xFFFF_FFFF -> addr 0 written 0x0000_0000.
REQ-041 Errors: base = HeapBase - 8 -> done_o and err_o at T + 1 with no cs. base = HeapBase + 0x4_0000, len = 8 -> err_o = 1. len = 0 -> done_o with err_o = 0.
REQ-042 Stall: hold gnt low 5 cycles in READ and in WRITE -> addr and wdata stable, exactly one read and one write, done_o delayed by 10 cycles.
REQ-043 Reset in WRITE of the word-crossing case -> cs drops immediately, no done_o, req_ready_o = 1 after reset release.

Source files
------------

// File: rtl/cheri_pkg.sv
// Shared constants and the painter state encoding for the CHERI TSMAP revocation painter.
package cheri_pkg;

   localparam int unsigned TSMAP_GRAN_SHIFT = 3;
   localparam int unsigned TSMAP_WORD_BITS  = 5;

   typedef enum logic [2:0] {
      PS_IDLE  = 3'd0,
      PS_READ  = 3'd1,
      PS_LATCH = 3'd2,
      PS_WRITE = 3'd3,
      PS_DONE  = 3'd4
   } painter_state_e;

endpackage

// File: rtl/cheri_tsmap_mask_gen.sv
// Combinational bit mask for one TSMAP word: trims bits below lo on the first word
// and bits above hi on the last word of a painted region.
module cheri_tsmap_mask_gen
   import cheri_pkg::*;
(
   input  logic [TSMAP_WORD_BITS-1:0] lo_i,
   input  logic [TSMAP_WORD_BITS-1:0] hi_i,
   input  logic                       first_i,
   input  logic                       last_i,
   output logic [31:0]                mask_o
);

   always_comb begin
      mask_o = '1;
      if (first_i) mask_o = mask_o & ({32{1'b1}} << lo_i);
      if (last_i)  mask_o = mask_o & ({32{1'b1}} >> (5'd31 - hi_i));
   end

endmodule

// File: rtl/cheri_tsmap_painter.sv
// Paints (sets or clears) the TSMAP revocation bits covering a heap byte range,
// one read-modify-write per 32-bit TSMAP word.
module cheri_tsmap_painter
   import cheri_pkg::*;
#(
   parameter logic [31:0] HeapBase  = 32'h2001_0000,
   parameter int unsigned TSMapSize = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_base_i,
   input  logic [31:0] req_len_i,
   input  logic        req_set_i,
   output logic        done_o,
   output logic        err_o,
   output logic        busy_o,
   output logic        tsmap_cs_o,
   output logic        tsmap_we_o,
   output logic [15:0] tsmap_addr_o,
   output logic [31:0] tsmap_wdata_o,
   input  logic        tsmap_gnt_i,
   input  logic [31:0] tsmap_rdata_i
);

   localparam logic [31:0] MapWords = 32'(TSMapSize);

   painter_state_e state_q, state_d;
   logic [31:0]    g0_q, g0_d, g1_q, g1_d;
   logic [26:0]    word_q, word_d;
   logic [31:0]    data_q, data_d;
   logic           set_q, set_d, err_q, err_d;

   logic [32:0]    end33;
   logic [31:0]    g0_acc, g1_acc;
   logic           req_err, req_zero;
   logic           first_word, last_word;
   logic [31:0]    mask;

   // End address is computed one bit wider so a wrap past 4 GiB is detectable.
   assign end33    = {1'b0, req_base_i} + {1'b0, req_len_i} - 33'd1;
   assign g0_acc   = (req_base_i - HeapBase) >> TSMAP_GRAN_SHIFT;
   assign g1_acc   = (end33[31:0] - HeapBase) >> TSMAP_GRAN_SHIFT;
   assign req_zero = (req_len_i == 32'd0);
   assign req_err  = !req_zero &&
                     ((req_base_i < HeapBase) || end33[32] ||
                      ({5'd0, g1_acc[31:TSMAP_WORD_BITS]} >= MapWords));

   assign first_word = (word_q == g0_q[31:TSMAP_WORD_BITS]);
   assign last_word  = (word_q == g1_q[31:TSMAP_WORD_BITS]);

   cheri_tsmap_mask_gen u_mask_gen (
      .lo_i    (g0_q[TSMAP_WORD_BITS-1:0]),
      .hi_i    (g1_q[TSMAP_WORD_BITS-1:0]),
      .first_i (first_word),
      .last_i  (last_word),
      .mask_o  (mask)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= PS_IDLE;
         g0_q    <= '0;
         g1_q    <= '0;
         word_q  <= '0;
         data_q  <= '0;
         set_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         g0_q    <= g0_d;
         g1_q    <= g1_d;
         word_q  <= word_d;
         data_q  <= data_d;
         set_q   <= set_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      g0_d    = g0_q;
      g1_d    = g1_q;
      word_d  = word_q;
      data_d  = data_q;
      set_d   = set_q;
      err_d   = err_q;
      unique case (state_q)
         PS_IDLE: begin
            if (req_valid_i) begin
               g0_d    = g0_acc;
               g1_d    = g1_acc;
               set_d   = req_set_i;
               err_d   = req_err;
               word_d  = g0_acc[31:TSMAP_WORD_BITS];
               state_d = (req_err || req_zero) ? PS_DONE : PS_READ;
            end
         end
         PS_READ:  if (tsmap_gnt_i) state_d = PS_LATCH;
         PS_LATCH: begin
            data_d  = tsmap_rdata_i;
            state_d = PS_WRITE;
         end
         PS_WRITE: begin
            if (tsmap_gnt_i) begin
               if (last_word) begin
                  state_d = PS_DONE;
               end else begin
                  word_d  = word_q + 27'd1;
                  state_d = PS_READ;
               end
            end
         end
         PS_DONE:  state_d = PS_IDLE;
         default:  state_d = PS_IDLE;
      endcase
   end

   assign req_ready_o   = (state_q == PS_IDLE);
   assign busy_o        = (state_q != PS_IDLE);
   assign done_o        = (state_q == PS_DONE);
   assign err_o         = done_o && err_q;
   assign tsmap_cs_o    = (state_q == PS_READ) || (state_q == PS_WRITE);
   assign tsmap_we_o    = (state_q == PS_WRITE);
   assign tsmap_addr_o  = word_q[15:0];
   assign tsmap_wdata_o = set_q ? (data_q | mask) : (data_q & ~mask);

endmodule

// File: tb/tb_cheri_tsmap_painter.sv
// Scoreboard bench for cheri_tsmap_painter: directed requests push expected TSMAP
// writes and completions; a negedge monitor pops and compares them.
module tb_cheri_tsmap_painter;

   localparam logic [31:0] HB = 32'h2001_0000;

   logic        clk, rst_ni;
   logic        req_valid, req_ready, req_set;
   logic [31:0] req_base, req_len;
   logic        done, err, busy;
   logic        cs, we, gnt;
   logic [15:0] addr;
   logic [31:0] wdata, rdata, rd_val;

   typedef struct {logic [15:0] addr; logic [31:0] data;} wr_t;
   typedef struct {logic err; int lat;} dn_t;

   wr_t exp_wr[$];
   dn_t exp_dn[$];
   wr_t ew;
   dn_t ed;

   int checks = 0, errors = 0;
   int cyc = 0, acc_cyc = 0, reads = 0, writes = 0;
   int r0, w0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_addr;
   logic [31:0] prev_wdata;

   cheri_tsmap_painter #(.HeapBase(HB), .TSMapSize(1024)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_base_i    (req_base),
      .req_len_i     (req_len),
      .req_set_i     (req_set),
      .done_o        (done),
      .err_o         (err),
      .busy_o        (busy),
      .tsmap_cs_o    (cs),
      .tsmap_we_o    (we),
      .tsmap_addr_o  (addr),
      .tsmap_wdata_o (wdata),
      .tsmap_gnt_i   (gnt),
      .tsmap_rdata_i (rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // TSMAP model: returns rd_val the cycle after a granted read.
   always @(posedge clk) begin
      if (cs && gnt && !we) rdata <= rd_val;
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      cyc++;
      if (req_valid && req_ready) acc_cyc = cyc;
      if (cs && prev_stall) begin
         chk("addr_stable", 32'(addr), 32'(prev_addr));
         if (we) chk("wdata_stable", wdata, prev_wdata);
      end
      prev_stall = cs && !gnt;
      prev_addr  = addr;
      prev_wdata = wdata;
      if (cs && gnt) begin
         if (we) begin
            writes++;
            if (exp_wr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr 0x%04h data 0x%08h, none expected", addr, wdata);
            end else begin
               ew = exp_wr.pop_front();
               chk("wr_addr", 32'(addr), 32'(ew.addr));
               chk("wr_data", wdata, ew.data);
            end
         end else begin
            reads++;
         end
      end
      if (done) begin
         if (exp_dn.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: err %0b, none expected", err);
         end else begin
            ed = exp_dn.pop_front();
            chk("done_err", 32'(err), 32'(ed.err));
            chk("done_latency", 32'(cyc - acc_cyc), 32'(ed.lat));
         end
      end
   end

   task automatic issue(input logic [31:0] b, input logic [31:0] l, input logic s);
      int n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!req_ready) begin
         errors++;
         $display("FAIL ready_timeout: req_ready 0 expected 1");
      end
      req_valid = 1'b1;
      req_base  = b;
      req_len   = l;
      req_set   = s;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!req_ready) begin
         errors++;
         $display("FAIL idle_timeout: req_ready 0 expected 1");
      end
      @(posedge clk); #1;
   endtask

   task automatic push_wr(input logic [15:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_wr.push_back(w);
   endtask

   task automatic push_dn(input logic e, input int lat);
      dn_t d;
      d.err = e;
      d.lat = lat;
      exp_dn.push_back(d);
   endtask

   initial begin
      rst_ni    = 1'b0;
      gnt       = 1'b1;
      req_valid = 1'b0;
      req_base  = '0;
      req_len   = '0;
      req_set   = 1'b0;
      rd_val    = '0;
      rdata     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      chk("rst_err",   32'(err), 32'd0);
      chk("rst_cs",    32'(cs), 32'd0);
      chk("rst_we",    32'(we), 32'd0);
      chk("rst_addr",  32'(addr), 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      rst_ni = 1'b1;
      @(posedge clk); #1;

      // single word set
      rd_val = 32'h0000_0001;
      push_wr(16'd0, 32'h0000_001D);
      push_dn(1'b0, 4);
      issue(HB + 32'h10, 32'h18, 1'b1);
      wait_idle();

      // crossing into the next word
      rd_val = 32'h0;
      push_wr(16'd0, 32'h8000_0000);
      push_wr(16'd1, 32'h0000_0001);
      push_dn(1'b0, 7);
      issue(HB + 32'hF8, 32'h10, 1'b1);
      wait_idle();

      // full word clear
      rd_val = 32'hFFFF_FFFF;
      push_wr(16'd0, 32'h0000_0000);
      push_dn(1'b0, 4);
      issue(HB, 32'h100, 1'b0);
      wait_idle();

      // single granule set, existing bits preserved
      rd_val = 32'h0000_00FF;
      push_wr(16'd0, 32'h0000_01FF);
      push_dn(1'b0, 4);
      issue(HB + 32'h40, 32'h8, 1'b1);
      wait_idle();

      // partial clear inside word 5
      rd_val = 32'hFFFF_FFFF;
      push_wr(16'd5, 32'hFFFF_FFCF);
      push_dn(1'b0, 4);
      issue(HB + 32'h520, 32'h10, 1'b0);
      wait_idle();

      // last valid TSMAP word, top bit
      rd_val = 32'h0;
      push_wr(16'd1023, 32'h8000_0000);
      push_dn(1'b0, 4);
      issue(HB + 32'h3_FFF8, 32'h8, 1'b1);
      wait_idle();

      // rejected and zero-length requests: no TSMAP traffic
      r0 = reads;
      w0 = writes;
      push_dn(1'b1, 1);
      issue(HB - 32'h8, 32'h8, 1'b1);
      wait_idle();
      push_dn(1'b1, 1);
      issue(HB + 32'h4_0000, 32'h8, 1'b1);
      wait_idle();
      push_dn(1'b1, 1);
      issue(32'hFFFF_FFF8, 32'h10, 1'b1);
      wait_idle();
      push_dn(1'b0, 1);
      issue(HB, 32'h0, 1'b1);
      wait_idle();
      chk("err_no_reads",  32'(reads), 32'(r0));
      chk("err_no_writes", 32'(writes), 32'(w0));

      // grant stalls of 5 cycles in READ and in WRITE
      r0 = reads;
      w0 = writes;
      rd_val = 32'h0000_0001;
      gnt = 1'b0;
      push_wr(16'd0, 32'h0000_001D);
      push_dn(1'b0, 14);
      issue(HB + 32'h10, 32'h18, 1'b1);
      repeat (5) begin @(posedge clk); #1; end
      gnt = 1'b1;
      @(posedge clk); #1;
      gnt = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      gnt = 1'b1;
      wait_idle();
      chk("stall_reads",  32'(reads - r0), 32'd1);
      chk("stall_writes", 32'(writes - w0), 32'd1);

      // reset while in WRITE of a word-crossing request
      rd_val = 32'h0;
      issue(HB + 32'hF8, 32'h10, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_we", 32'(we), 32'd1);
      rst_ni = 1'b0;
      #1;
      chk("rst_cs_drop", 32'(cs), 32'd0);
      repeat (2) begin @(posedge clk); #1; end
      rst_ni = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      repeat (10) begin @(posedge clk); #1; end
      chk("post_rst_cs", 32'(cs), 32'd0);

      chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
      chk("dn_queue_empty", 32'(exp_dn.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
